// File: rtl/bg_line_collector.sv
// bg_line_collector
//
// Collects the four per-column BG stage packets (bgno 0..3) for one screen
// column, resolves the frontmost opaque layer, and stores the result in a
// double-buffered 240-entry line buffer. When column 239 completes, the
// write and display banks swap and line_ready pulses for one cycle.
//
// Ports:
//   clock       rising-edge clock
//   rst         synchronous active-high reset
//   pkt_valid   bg_packet is valid this cycle
//   bg_packet   {bgused, transparent, priority[1:0], bitmapped, color[14:0]}
//   pkt_bgno    BG number of bg_packet (expected in order 0,1,2,3)
//   hcount      screen column of bg_packet
//   rd_en       read request to the display bank
//   rd_addr     read column, 0..239 (larger returns 0)
//   rd_data     {opaque, priority[1:0], bgno[1:0], bitmapped, color[14:0]}
//   line_ready  one-cycle pulse after a completed line is swapped to display
//   seq_err     sticky bgno sequence violation flag (cleared only by rst)

module bg_line_collector (
  input  logic        clock,
  input  logic        rst,
  input  logic        pkt_valid,
  input  logic [19:0] bg_packet,
  input  logic [1:0]  pkt_bgno,
  input  logic [7:0]  hcount,
  input  logic        rd_en,
  input  logic [7:0]  rd_addr,
  output logic [20:0] rd_data,
  output logic        line_ready,
  output logic        seq_err
);

  localparam logic [7:0] NUM_COLS = 8'd240;
  localparam logic [7:0] LAST_COL = 8'd239;

  // The accumulator layout is exactly the stored entry layout. An empty
  // accumulator is kept all-zero, so it can be written to the bank as-is.
  typedef struct packed {
    logic        valid;
    logic [1:0]  prio;
    logic [1:0]  bgno;
    logic        bitmapped;
    logic [14:0] color;
  } entry_t;

  entry_t     acc, acc_next, pkt_entry;
  logic [1:0] exp_bgno, exp_next;
  logic       bank;         // index of the write bank; display is ~bank
  logic       pkt_opaque;
  logic       in_order;
  logic       err_set;
  logic       wr_en;
  logic       last_col;
  entry_t     rd_word;

  entry_t bank0 [240];
  entry_t bank1 [240];

  assign pkt_opaque = bg_packet[19] & ~bg_packet[18];
  assign in_order   = (pkt_bgno == exp_bgno);
  assign pkt_entry  = '{valid:     1'b1,
                        prio:      bg_packet[17:16],
                        bgno:      pkt_bgno,
                        bitmapped: bg_packet[15],
                        color:     bg_packet[14:0]};

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    acc_next = acc;
    exp_next = exp_bgno;
    err_set  = 1'b0;
    wr_en    = 1'b0;
    if (pkt_valid) begin
      if (pkt_bgno == 2'd0) begin
        // bgno 0 always starts a column; arriving early is a resync.
        acc_next = pkt_opaque ? pkt_entry : '0;
        exp_next = 2'd1;
        err_set  = !in_order;
      end else if (in_order) begin
        // Strict less-than: on a priority tie the lower bgno already held wins.
        if (pkt_opaque && (!acc.valid || (bg_packet[17:16] < acc.prio)))
          acc_next = pkt_entry;
        exp_next = exp_bgno + 2'd1;
        wr_en    = (pkt_bgno == 2'd3) && (hcount < NUM_COLS);
      end else begin
        // Out-of-order bgno 1..3: drop the column and wait for a new bgno 0.
        acc_next = '0;
        exp_next = 2'd0;
        err_set  = 1'b1;
      end
    end
  end

  assign last_col = wr_en && (hcount == LAST_COL);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the read below therefore sees the pre-swap bank.
  always_ff @(posedge clock) begin
    if (rst) begin
      acc        <= '0;
      exp_bgno   <= 2'd0;
      bank       <= 1'b0;
      line_ready <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      acc        <= acc_next;
      exp_bgno   <= exp_next;
      line_ready <= last_col;
      if (last_col) bank    <= ~bank;
      if (err_set)  seq_err <= 1'b1;
    end
  end

  // NOTE: the line banks have no reset; reset only suppresses the write so
  // a partial column is discarded and the displayed line stays readable.
  always_ff @(posedge clock) begin
    if (wr_en && !rst) begin
      if (bank) bank1[hcount] <= acc_next;
      else      bank0[hcount] <= acc_next;
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_addr < NUM_COLS)
      rd_word = bank ? bank0[rd_addr] : bank1[rd_addr];
  end

  always_ff @(posedge clock) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= rd_word;
  end

endmodule

// File: tb/tb_bg_line_collector.sv
// Directed self-checking bench for bg_line_collector.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, half a cycle after the rising edge that produced them.

module tb_bg_line_collector;

  logic        clock = 1'b0;
  logic        rst;
  logic        pkt_valid;
  logic [19:0] bg_packet;
  logic [1:0]  pkt_bgno;
  logic [7:0]  hcount;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [20:0] rd_data;
  logic        line_ready;
  logic        seq_err;

  int checks = 0;
  int errors = 0;
  int lr_pulses = 0;
  int lr_base;

  bg_line_collector dut (
    .clock      (clock),
    .rst        (rst),
    .pkt_valid  (pkt_valid),
    .bg_packet  (bg_packet),
    .pkt_bgno   (pkt_bgno),
    .hcount     (hcount),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .line_ready (line_ready),
    .seq_err    (seq_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (line_ready === 1'b1) lr_pulses++;

  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pk(input logic bu, input logic tr, input logic [1:0] pr,
                                     input logic bm, input logic [14:0] c);
    return {bu, tr, pr, bm, c};
  endfunction

  function automatic logic [20:0] ent(input logic [1:0] pr, input logic [1:0] b,
                                      input logic bm, input logic [14:0] c);
    return {1'b1, pr, b, bm, c};
  endfunction

  task automatic send(input logic [1:0] b, input logic [19:0] p, input logic [7:0] h);
    @(negedge clock);
    pkt_valid = 1'b1;
    pkt_bgno  = b;
    bg_packet = p;
    hcount    = h;
  endtask

  task automatic idle();
    @(negedge clock);
    pkt_valid = 1'b0;
  endtask

  // Default column: bgno0 opaque prio 3 with the given color; the rest are
  // transparent with prio 0 so they must never win.
  task automatic default_col(input logic [7:0] h, input logic [14:0] c);
    send(2'd0, pk(1, 0, 2'd3, 0, c), h);
    send(2'd1, pk(1, 1, 2'd0, 0, 15'h7fff), h);
    send(2'd2, pk(1, 1, 2'd0, 1, 15'h7fff), h);
    send(2'd3, pk(0, 0, 2'd0, 0, 15'h7fff), h);
  endtask

  task automatic rd(input logic [7:0] a, input logic [20:0] exp, input string tag);
    @(negedge clock);
    rd_en   = 1'b1;
    rd_addr = a;
    @(negedge clock);
    rd_en = 1'b0;
    check(tag, rd_data, exp);
  endtask

  initial begin
    rst = 1'b1; pkt_valid = 1'b0; bg_packet = '0; pkt_bgno = '0;
    hcount = '0; rd_en = 1'b0; rd_addr = '0;
    repeat (2) @(negedge clock);
    check("reset rd_data", rd_data, 21'd0);
    check("reset line_ready", {20'd0, line_ready}, 21'd0);
    check("reset seq_err", {20'd0, seq_err}, 21'd0);
    rst = 1'b0;

    // Line A into bank 0, line B into bank 1; display is then bank 1 (line B).
    for (int h = 0; h < 240; h++) default_col(8'(h), 15'(h));
    idle(); idle();
    check("line A pulses", 21'(lr_pulses), 21'd1);
    for (int h = 0; h < 240; h++) default_col(8'(h), 15'(h + 'h200));
    idle(); idle();
    check("line B pulses", 21'(lr_pulses), 21'd2);
    rd(8'd5, ent(2'd3, 2'd0, 1'b0, 15'h205), "B col5");
    rd(8'd239, ent(2'd3, 2'd0, 1'b0, 15'h2ef), "B col239");

    // Partial line R into bank 0, reset after bgno1 of column 239.
    for (int h = 0; h < 239; h++) default_col(8'(h), 15'(h + 'h300));
    send(2'd0, pk(1, 0, 2'd0, 0, 15'h3ef), 8'd239);
    send(2'd1, pk(1, 0, 2'd0, 0, 15'h3ee), 8'd239);
    @(negedge clock);
    pkt_valid = 1'b0;
    rd_en = 1'b1; rd_addr = 8'd100;
    @(negedge clock);
    rd_en = 1'b0;
    check("pre-reset read", rd_data, ent(2'd3, 2'd0, 1'b0, 15'h264));
    rst = 1'b1;
    @(negedge clock);
    check("mid rst rd_data", rd_data, 21'd0);
    check("mid rst line_ready", {20'd0, line_ready}, 21'd0);
    check("mid rst seq_err", {20'd0, seq_err}, 21'd0);
    rst = 1'b0;
    repeat (3) idle();
    check("no swap after rst", 21'(lr_pulses), 21'd2);
    rd(8'd5, ent(2'd3, 2'd0, 1'b0, 15'h205), "display kept col5");

    // Line C into bank 0 with the directed columns.
    lr_base = lr_pulses;
    for (int h = 0; h < 240; h++) begin
      case (h)
        5: begin
          send(2'd0, pk(1, 0, 2'd2, 0, 15'h0011), 8'(h));
          send(2'd1, pk(1, 0, 2'd1, 0, 15'h0022), 8'(h));
          send(2'd2, pk(1, 0, 2'd1, 0, 15'h0033), 8'(h));
          send(2'd3, pk(1, 0, 2'd3, 0, 15'h0044), 8'(h));
        end
        7: begin
          send(2'd0, pk(0, 0, 2'd0, 0, 15'h0001), 8'(h));
          send(2'd1, pk(1, 1, 2'd0, 0, 15'h0002), 8'(h));
          send(2'd2, pk(0, 1, 2'd0, 0, 15'h0003), 8'(h));
          send(2'd3, pk(1, 1, 2'd0, 0, 15'h0004), 8'(h));
        end
        9: begin
          idle();
          check("seq_err before col9", {20'd0, seq_err}, 21'd0);
          send(2'd0, pk(1, 0, 2'd0, 0, 15'h0aaa), 8'(h));
          send(2'd1, pk(1, 0, 2'd0, 0, 15'h0bbb), 8'(h));
          send(2'd3, pk(1, 0, 2'd0, 0, 15'h0ccc), 8'(h));
          idle();
          check("seq_err after col9", {20'd0, seq_err}, 21'd1);
        end
        10: begin
          send(2'd0, pk(1, 1, 2'd0, 0, 15'h0001), 8'(h));
          send(2'd1, pk(1, 0, 2'd2, 0, 15'h0055), 8'(h));
          send(2'd2, pk(1, 0, 2'd1, 0, 15'h0066), 8'(h));
          send(2'd3, pk(1, 0, 2'd0, 0, 15'h0077), 8'(h));
        end
        11: begin
          send(2'd0, pk(1, 0, 2'd0, 0, 15'h00aa), 8'(h));
          send(2'd1, pk(1, 1, 2'd0, 0, 15'h0001), 8'(h));
          send(2'd0, pk(1, 1, 2'd0, 0, 15'h0002), 8'(h));
          send(2'd1, pk(0, 0, 2'd0, 0, 15'h0003), 8'(h));
          send(2'd2, pk(1, 0, 2'd2, 0, 15'h00bb), 8'(h));
          send(2'd3, pk(1, 0, 2'd3, 0, 15'h00cc), 8'(h));
        end
        20: begin
          send(2'd0, pk(1, 0, 2'd1, 0, 15'h0010), 8'(h));
          send(2'd1, pk(0, 0, 2'd0, 0, 15'h0020), 8'(h));
          send(2'd2, pk(1, 0, 2'd0, 1, 15'h7fff), 8'(h));
          send(2'd3, pk(1, 1, 2'd0, 0, 15'h0030), 8'(h));
        end
        239: begin
          // Read issued in the swap cycle must see the pre-swap display bank.
          rd_en = 1'b1; rd_addr = 8'd5;
          default_col(8'(h), 15'(h + 'h100));
        end
        default: default_col(8'(h), 15'(h + 'h100));
      endcase
    end
    idle();
    rd_en = 1'b0;
    check("line_ready after 239", {20'd0, line_ready}, 21'd1);
    check("swap-cycle read", rd_data, ent(2'd3, 2'd0, 1'b0, 15'h205));
    default_col(8'd240, 15'h0123);
    idle();
    check("line_ready one cycle", {20'd0, line_ready}, 21'd0);
    repeat (3) idle();
    check("line C one pulse", 21'(lr_pulses - lr_base), 21'd1);
    check("seq_err sticky", {20'd0, seq_err}, 21'd1);

    rd(8'd5, ent(2'd1, 2'd1, 1'b0, 15'h0022), "col5 tie");
    @(negedge clock);
    rd_addr = 8'd7;
    @(negedge clock);
    check("rd_data hold", rd_data, ent(2'd1, 2'd1, 1'b0, 15'h0022));
    rd(8'd7, 21'd0, "col7 empty");
    rd(8'd9, ent(2'd3, 2'd0, 1'b0, 15'h0309), "col9 unwritten");
    rd(8'd10, ent(2'd0, 2'd3, 1'b0, 15'h0077), "col10");
    rd(8'd11, ent(2'd2, 2'd2, 1'b0, 15'h00bb), "col11 resync");
    rd(8'd20, ent(2'd0, 2'd2, 1'b1, 15'h7fff), "col20 bitmapped");
    rd(8'd100, ent(2'd3, 2'd0, 1'b0, 15'h0164), "col100");
    rd(8'd239, ent(2'd3, 2'd0, 1'b0, 15'h01ef), "col239");
    rd(8'd240, 21'd0, "addr240");
    rd(8'd255, 21'd0, "addr255");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
